program_store_banked: RTL and testbench

Parametrised, writable, multi-bank program store for the K2 processor; replaces the fixed per-program instruction decoders. The fetch path reads the instruction combinationally from the current PC out of the active bank. A loader port streams new programs into any bank through a valid/ready handshake, and raises `busy` so the core is held while a load is in progress. Run-time bank switching selects which stored program executes.

---
 rtl/program_store_banked.sv | 162 ++++++++++++++++
 tb/tb_program_store_banked.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_store_banked.sv
`default_nettype none
// ============================================================================
// Module   : program_store_banked
// Brief    : Writable multi-bank program store for the K2 core. Combinational
//            fetch from the active bank, valid/ready loader into any bank,
//            run-time bank switching guarded against in-flight loads.
// Revision : 1.0  initial release
// ============================================================================
module program_store_banked #(
  parameter int                INST_W   = 8,
  parameter int                ADDR_W   = 4,
  parameter int                BANKS    = 4,
  parameter logic [INST_W-1:0] NOP_INST = 8'h00,
  localparam int               BANK_W   = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  // fetch port
  input  logic [ADDR_W-1:0] pc,
  output logic [INST_W-1:0] inst,
  // bank selection
  input  logic              sel_en,
  input  logic [BANK_W-1:0] sel_bank,
  output logic [BANK_W-1:0] active_bank,
  // loader port
  input  logic              ld_start,
  input  logic [BANK_W-1:0] ld_bank,
  input  logic [ADDR_W-1:0] ld_len,
  input  logic              ld_abort,
  input  logic              ld_valid,
  input  logic [INST_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              busy,
  output logic              ld_done,
  output logic              ld_err
);

  localparam int                DEPTH     = 1 << ADDR_W;
  // Length register is one bit wider so a full-bank load (ld_len == 0) fits.
  localparam logic [ADDR_W:0]   LEN_FULL  = (ADDR_W+1)'(DEPTH);
  // Bank bound widened by one bit so it is representable even when BANKS is
  // a power of two.
  localparam logic [BANK_W:0]   BANK_LIM  = (BANK_W+1)'(BANKS);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t             state;
  logic [BANK_W-1:0]  bank;      // target bank of the load in progress
  logic [ADDR_W:0]    len;       // words to accept in this load
  logic [ADDR_W:0]    cnt;       // words accepted so far; low bits are the write pointer
  logic [ADDR_W:0]    cnt_next;
  logic [ADDR_W-1:0]  ptr;
  logic               accept;
  logic               ld_bank_ok;
  logic               sel_bank_ok;
  logic [INST_W-1:0]  rd_word;

  logic [INST_W-1:0]  mem [BANKS][DEPTH];

  assign ptr         = cnt[ADDR_W-1:0];
  assign cnt_next    = cnt + 1'b1;
  assign accept      = (state == LOAD) && ld_valid;
  assign ld_bank_ok  = ({1'b0, ld_bank}  < BANK_LIM);
  assign sel_bank_ok = ({1'b0, sel_bank} < BANK_LIM);

  // Loader FSM, bank selection and all handshake/status flags (registered).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bank        <= '0;
      len         <= '0;
      cnt         <= '0;
      active_bank <= '0;
      busy        <= 1'b0;
      ld_ready    <= 1'b0;
      ld_done     <= 1'b0;
      ld_err      <= 1'b0;
    end else begin
      ld_done <= 1'b0;
      ld_err  <= 1'b0;
      case (state)
        IDLE: begin
          // A switch and a load start requested together both take effect.
          if (sel_en && sel_bank_ok) begin
            active_bank <= sel_bank;
          end
          if (ld_start) begin
            if (ld_bank_ok) begin
              state    <= LOAD;
              bank     <= ld_bank;
              len      <= (ld_len == '0) ? LEN_FULL : {1'b0, ld_len};
              cnt      <= '0;
              busy     <= 1'b1;
              ld_ready <= 1'b1;
            end else begin
              ld_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          // ld_start and sel_en are deliberately ignored here (not queued).
          if (accept) begin
            cnt <= cnt_next;
          end
          if (ld_abort) begin
            // Abort wins over completion: no ld_done even on the last word.
            state    <= IDLE;
            busy     <= 1'b0;
            ld_ready <= 1'b0;
          end else if (accept && (cnt_next == len)) begin
            state    <= IDLE;
            busy     <= 1'b0;
            ld_ready <= 1'b0;
            ld_done  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          ld_ready <= 1'b0;
        end
      endcase
    end
  end

  // Program storage: cleared by reset, written one word per accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < BANKS; b++) begin
        for (int w = 0; w < DEPTH; w++) begin
          mem[b][w] <= '0;
        end
      end
    end else if (accept) begin
      for (int b = 0; b < BANKS; b++) begin
        for (int w = 0; w < DEPTH; w++) begin
          if ((bank == BANK_W'(b)) && (ptr == ADDR_W'(w))) begin
            mem[b][w] <= ld_data;
          end
        end
      end
    end
  end

  // Fetch read: select the active bank, then the word at pc.
  always_comb begin
    rd_word = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (active_bank == BANK_W'(b)) begin
        rd_word = mem[b][pc];
      end
    end
  end

  // The core sees NOPs while a load holds it stalled.
  assign inst = busy ? NOP_INST : rd_word;

endmodule
`default_nettype wire

// File: tb/tb_program_store_banked.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_store_banked
// Brief    : Directed, table-driven bench for program_store_banked. Uses
//            BANKS = 3 so that an out-of-range bank number is encodable on the
//            2-bit bank ports, and a distinctive NOP value to observe stalls.
// Revision : 1.0  initial release
// ============================================================================
module tb_program_store_banked;

  localparam int          INST_W = 8;
  localparam int          ADDR_W = 4;
  localparam int          BANKS  = 3;
  localparam int          BANK_W = 2;
  localparam logic [7:0]  NOP    = 8'hEE;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] pc;
  logic [INST_W-1:0] inst;
  logic              sel_en;
  logic [BANK_W-1:0] sel_bank;
  logic [BANK_W-1:0] active_bank;
  logic              ld_start;
  logic [BANK_W-1:0] ld_bank;
  logic [ADDR_W-1:0] ld_len;
  logic              ld_abort;
  logic              ld_valid;
  logic [INST_W-1:0] ld_data;
  logic              ld_ready;
  logic              busy;
  logic              ld_done;
  logic              ld_err;

  int vectors = 0;
  int miscompares = 0;

  program_store_banked #(
    .INST_W   (INST_W),
    .ADDR_W   (ADDR_W),
    .BANKS    (BANKS),
    .NOP_INST (NOP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .inst        (inst),
    .sel_en      (sel_en),
    .sel_bank    (sel_bank),
    .active_bank (active_bank),
    .ld_start    (ld_start),
    .ld_bank     (ld_bank),
    .ld_len      (ld_len),
    .ld_abort    (ld_abort),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .busy        (busy),
    .ld_done     (ld_done),
    .ld_err      (ld_err)
  );

  always #5 clk = ~clk;

  // Read-back vectors: {bank, pc, expected instruction}.
  typedef struct {
    logic [BANK_W-1:0] bank;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] exp;
  } rd_vec_t;

  rd_vec_t rv [0:15];
  logic [7:0] full_data [0:8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge; inputs change and outputs are
  // sampled there, well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic select_bank(input logic [BANK_W-1:0] b);
    sel_en   = 1'b1;
    sel_bank = b;
    tick();
    sel_en   = 1'b0;
  endtask

  task automatic run_reads(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (active_bank !== rv[i].bank) select_bank(rv[i].bank);
      pc = rv[i].pc;
      #1;
      chk($sformatf("read[%0d] b%0d pc%0d", i, rv[i].bank, rv[i].pc),
          32'(inst), 32'(rv[i].exp));
    end
  endtask

  task automatic start_load(input logic [BANK_W-1:0] b, input logic [ADDR_W-1:0] l);
    ld_start = 1'b1;
    ld_bank  = b;
    ld_len   = l;
    tick();
    ld_start = 1'b0;
  endtask

  initial begin
    // Full-rate load contents for bank 0.
    full_data = '{8'h08, 8'h19, 8'h20, 8'h10, 8'h70, 8'h00, 8'h14, 8'h04, 8'hB2};
    // 0..3: bank 0 after full-rate load
    rv[0]  = '{2'd0, 4'd3,  8'h10};
    rv[1]  = '{2'd0, 4'd8,  8'hB2};
    rv[2]  = '{2'd0, 4'd9,  8'h00};
    rv[3]  = '{2'd0, 4'd0,  8'h08};
    // 4..7: bank 1 after gapped full-depth load
    rv[4]  = '{2'd1, 4'd15, 8'hAF};
    rv[5]  = '{2'd1, 4'd5,  8'hA5};
    rv[6]  = '{2'd1, 4'd6,  8'hA6};
    rv[7]  = '{2'd1, 4'd0,  8'hA0};
    // 8..15: bank 2 after abort on the 4th accepted word
    rv[8]  = '{2'd2, 4'd0,  8'hC0};
    rv[9]  = '{2'd2, 4'd1,  8'hC1};
    rv[10] = '{2'd2, 4'd2,  8'hC2};
    rv[11] = '{2'd2, 4'd3,  8'hC3};
    rv[12] = '{2'd2, 4'd4,  8'h54};
    rv[13] = '{2'd2, 4'd5,  8'h55};
    rv[14] = '{2'd2, 4'd6,  8'h56};
    rv[15] = '{2'd2, 4'd7,  8'h57};

    rst_n = 1'b0; pc = '0; sel_en = 1'b0; sel_bank = '0;
    ld_start = 1'b0; ld_bank = '0; ld_len = '0; ld_abort = 1'b0;
    ld_valid = 1'b0; ld_data = '0;

    // ---------------- reset defaults ----------------
    #23 rst_n = 1'b1;
    tick();
    chk("rst busy", 32'(busy), 0);
    chk("rst ld_ready", 32'(ld_ready), 0);
    chk("rst ld_done", 32'(ld_done), 0);
    chk("rst ld_err", 32'(ld_err), 0);
    chk("rst active_bank", 32'(active_bank), 0);
    for (int i = 0; i < 16; i++) begin
      pc = ADDR_W'(i);
      #1;
      chk($sformatf("rst inst pc%0d", i), 32'(inst), 0);
    end

    // ---------------- full-rate load, bank 0, 9 words ----------------
    start_load(2'd0, 4'd9);
    chk("fr busy after start", 32'(busy), 1);
    chk("fr ready after start", 32'(ld_ready), 1);
    chk("fr nop while busy", 32'(inst), 32'(NOP));
    for (int i = 0; i < 9; i++) begin
      ld_valid = 1'b1;
      ld_data  = full_data[i];
      tick();
      if (i < 8) begin
        chk($sformatf("fr busy w%0d", i), 32'(busy), 1);
        chk($sformatf("fr done early w%0d", i), 32'(ld_done), 0);
      end
    end
    ld_valid = 1'b0;
    chk("fr busy end", 32'(busy), 0);
    chk("fr ready end", 32'(ld_ready), 0);
    chk("fr ld_done", 32'(ld_done), 1);
    tick();
    chk("fr ld_done one cycle", 32'(ld_done), 0);
    run_reads(0, 3);

    // ---------------- gapped full-depth load, bank 1 ----------------
    start_load(2'd1, 4'd0);
    for (int i = 0; i < 16; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'hA0 + 8'(i);
      tick();
      if (i == 5) begin
        ld_valid = 1'b0;
        // Switch request while busy must be dropped.
        sel_en = 1'b1; sel_bank = 2'd1;
        tick();
        sel_en = 1'b0;
        chk("sw during load ignored", 32'(active_bank), 0);
        tick();
        tick();
        chk("gap still busy", 32'(busy), 1);
      end
    end
    ld_valid = 1'b0;
    chk("gap ld_done", 32'(ld_done), 1);
    chk("gap busy end", 32'(busy), 0);
    chk("sw not queued", 32'(active_bank), 0);
    select_bank(2'd1);
    chk("sw after done", 32'(active_bank), 1);
    for (int i = 0; i < 16; i++) begin
      pc = ADDR_W'(i);
      #1;
      chk($sformatf("gap word %0d", i), 32'(inst), 32'(8'hA0 + 8'(i)));
    end
    run_reads(4, 7);

    // ---------------- start + switch in same cycle; prefill bank 2 ----------------
    sel_en = 1'b1; sel_bank = 2'd2;
    start_load(2'd2, 4'd8);
    sel_en = 1'b0;
    chk("start+sel bank", 32'(active_bank), 2);
    chk("start+sel busy", 32'(busy), 1);
    for (int i = 0; i < 8; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'h50 + 8'(i);
      tick();
    end
    ld_valid = 1'b0;
    chk("prefill done", 32'(ld_done), 1);

    // ---------------- abort on 4th accepted word ----------------
    start_load(2'd2, 4'd8);
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'hC0 + 8'(i);
      ld_abort = (i == 3);
      tick();
    end
    ld_valid = 1'b0;
    ld_abort = 1'b0;
    chk("abort busy", 32'(busy), 0);
    chk("abort ready", 32'(ld_ready), 0);
    chk("abort no done", 32'(ld_done), 0);
    tick();
    chk("abort no done later", 32'(ld_done), 0);
    // Abort while idle must not disturb anything.
    ld_abort = 1'b1;
    tick();
    ld_abort = 1'b0;
    chk("idle abort busy", 32'(busy), 0);
    run_reads(8, 15);

    // ---------------- rejected start / out-of-range switch ----------------
    start_load(2'd3, 4'd2);
    chk("err pulse", 32'(ld_err), 1);
    chk("err busy", 32'(busy), 0);
    tick();
    chk("err one cycle", 32'(ld_err), 0);
    select_bank(2'd3);
    chk("sel out of range", 32'(active_bank), 2);

    // ---------------- ld_start during LOAD ignored ----------------
    start_load(2'd0, 4'd2);
    ld_start = 1'b1; ld_bank = 2'd1; ld_len = 4'd5;
    ld_valid = 1'b1; ld_data = 8'h31;
    tick();
    ld_start = 1'b0;
    chk("restart no err", 32'(ld_err), 0);
    chk("restart busy", 32'(busy), 1);
    ld_data = 8'h32;
    tick();
    ld_valid = 1'b0;
    chk("restart orig len done", 32'(ld_done), 1);
    select_bank(2'd0);
    pc = 4'd1; #1; chk("restart bank0 w1", 32'(inst), 32'h32);
    pc = 4'd2; #1; chk("restart bank0 w2 kept", 32'(inst), 32'h20);
    select_bank(2'd1);
    pc = 4'd0; #1; chk("restart bank1 untouched", 32'(inst), 32'hA0);

    // ---------------- reset mid-load ----------------
    start_load(2'd1, 4'd6);
    ld_valid = 1'b1; ld_data = 8'h77;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 0);
    chk("midrst ready", 32'(ld_ready), 0);
    chk("midrst bank", 32'(active_bank), 0);
    chk("midrst done", 32'(ld_done), 0);
    ld_valid = 1'b0;
    #3 rst_n = 1'b1;
    tick();
    chk("midrst done after", 32'(ld_done), 0);
    for (int b = 0; b < BANKS; b++) begin
      select_bank(BANK_W'(b));
      for (int i = 0; i < 16; i++) begin
        pc = ADDR_W'(i);
        #1;
        chk($sformatf("midrst clear b%0d pc%0d", b, i), 32'(inst), 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
